// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller:
// CSR map, FSM and pc_sel encodings, excep_info field bounds and reset values.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_RETURN   = 2'd2
  } trap_state_e;

  typedef enum logic [1:0] {
    PC_SEL_NORMAL = 2'b00,
    PC_SEL_TRAP   = 2'b01,
    PC_SEL_RETURN = 2'b10
  } pc_sel_e;

  // excep_info = {cause_type, mcause, mstatus_hint, mret}
  localparam int EI_CAUSE_TYPE_BIT = 31;
  localparam int EI_MCAUSE_HI      = 30;
  localparam int EI_MCAUSE_LO      = 24;
  localparam int EI_HINT_HI        = 23;
  localparam int EI_HINT_LO        = 16;
  localparam int EI_MRET_HI        = 15;
  localparam int EI_MRET_LO        = 0;

  localparam int MIP_MEIP_BIT = 11;

  localparam logic [15:0] MTVEC_RST_DEF    = 16'h0060;
  localparam logic [15:0] MAX_ROM_SIZE_DEF = 16'h007c;
  localparam logic [31:0] MSTATUS_RST      = 32'h0000_0001;

endpackage

// File: rtl/trap_controller_if.sv
// Bundle of exception-verifier, decoder, CSR and pipeline-control signals
// shared between the trap controller (slave) and its environment (master).
interface trap_controller_if;
  import trap_pkg::*;

  logic        exception;
  logic        interrup;
  logic [31:0] excep_info;
  logic [15:0] pc_curr;
  logic        mret_instr;
  logic        irq_ext;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mstatus;
  logic [31:0] mip;
  pc_sel_e     pc_sel;
  logic [15:0] trap_pc;
  logic        flush;
  logic        stall;

  modport master (
    output exception, interrup, excep_info, pc_curr, mret_instr, irq_ext,
           csr_we, csr_addr, csr_wdata,
    input  csr_rdata, mstatus, mip, pc_sel, trap_pc, flush, stall
  );

  modport slave (
    input  exception, interrup, excep_info, pc_curr, mret_instr, irq_ext,
           csr_we, csr_addr, csr_wdata,
    output csr_rdata, mstatus, mip, pc_sel, trap_pc, flush, stall
  );

endinterface

// File: rtl/trap_csr_file.sv
// Machine-mode CSR storage: trap capture, software writes with alignment and
// ROM-range filtering on mtvec/mepc, live external-interrupt bit, read mux.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [15:0] MTVEC_RST    = MTVEC_RST_DEF,
  parameter logic [15:0] MAX_ROM_SIZE = MAX_ROM_SIZE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        trap_en_i,
  input  logic [31:0] trap_mepc_i,
  input  logic [31:0] trap_mcause_i,
  input  logic        mstatus_set_i,
  input  logic        irq_ext_i,
  output logic [31:0] rdata_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mip_o
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mip_q, mip_d;
  logic        addr_legal;

  assign addr_legal = (wdata_i <= {16'h0, MAX_ROM_SIZE});

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mip_d     = mip_q;
    if (trap_en_i) begin
      mepc_d    = trap_mepc_i;
      mcause_d  = trap_mcause_i;
      mstatus_d = '0;
    end else if (mstatus_set_i) begin
      mstatus_d = MSTATUS_RST;
    end else if (wr_en_i) begin
      case (addr_i)
        CSR_MSTATUS: mstatus_d = wdata_i;
        CSR_MTVEC:   if (addr_legal) mtvec_d = {wdata_i[31:2], 2'b00};
        CSR_MEPC:    if (addr_legal) mepc_d = {wdata_i[31:2], 2'b00};
        CSR_MCAUSE:  mcause_d = wdata_i;
        CSR_MIP:     mip_d = wdata_i;
        default:     ;
      endcase
    end
    mip_d[MIP_MEIP_BIT] = irq_ext_i;
  end

  // NOTE: synchronous active-low reset; state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= {16'h0, MTVEC_RST};
      mepc_q    <= '0;
      mcause_q  <= '0;
      mip_q     <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mip_q     <= mip_d;
    end
  end

  always_comb begin
    case (addr_i)
      CSR_MSTATUS: rdata_o = mstatus_q;
      CSR_MTVEC:   rdata_o = mtvec_q;
      CSR_MEPC:    rdata_o = mepc_q;
      CSR_MCAUSE:  rdata_o = mcause_q;
      CSR_MIP:     rdata_o = mip_q;
      default:     rdata_o = '0;
    endcase
  end

  assign mstatus_o = mstatus_q;
  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign mip_o     = mip_q;

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: arbitrates exception > interrupt > mret > CSR write in IDLE
// and drives a one-cycle pipeline redirect to mtvec or back to mepc.
module trap_controller
  import trap_pkg::*;
#(
  parameter logic [15:0] MTVEC_RST    = MTVEC_RST_DEF,
  parameter logic [15:0] MAX_ROM_SIZE = MAX_ROM_SIZE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  trap_controller_if.slave  bus
);

  trap_state_e state_q, state_d;
  logic        csr_wr_en;
  logic        trap_en;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic        mstatus_set;
  logic [31:0] mstatus, mtvec, mepc;
  logic        mie_on, mie_off;
  logic        unused_bits;

  assign mie_on  = (mstatus == 32'h1);
  assign mie_off = (mstatus == 32'h0);
  assign unused_bits = ^{bus.excep_info[EI_HINT_HI:EI_HINT_LO], mtvec[31:16], mepc[31:16]};

  trap_csr_file #(
    .MTVEC_RST   (MTVEC_RST),
    .MAX_ROM_SIZE(MAX_ROM_SIZE)
  ) u_csr (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (csr_wr_en),
    .addr_i       (bus.csr_addr),
    .wdata_i      (bus.csr_wdata),
    .trap_en_i    (trap_en),
    .trap_mepc_i  (trap_mepc),
    .trap_mcause_i(trap_mcause),
    .mstatus_set_i(mstatus_set),
    .irq_ext_i    (bus.irq_ext),
    .rdata_o      (bus.csr_rdata),
    .mstatus_o    (mstatus),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc),
    .mip_o        (bus.mip)
  );

  assign bus.mstatus = mstatus;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = ST_IDLE;
    csr_wr_en   = 1'b0;
    trap_en     = 1'b0;
    trap_mepc   = '0;
    trap_mcause = '0;
    mstatus_set = 1'b0;
    bus.pc_sel  = PC_SEL_NORMAL;
    bus.trap_pc = '0;
    bus.flush   = 1'b0;
    bus.stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mie_on && bus.exception) begin
          trap_en     = 1'b1;
          trap_mepc   = {16'h0, bus.excep_info[EI_MRET_HI:EI_MRET_LO]};
          trap_mcause = {bus.excep_info[EI_CAUSE_TYPE_BIT], 24'h0,
                         bus.excep_info[EI_MCAUSE_HI:EI_MCAUSE_LO]};
          state_d     = ST_REDIRECT;
        end else if (mie_on && bus.interrup) begin
          trap_en     = 1'b1;
          trap_mepc   = {16'h0, bus.pc_curr};
          trap_mcause = {1'b1, 24'h0, bus.excep_info[EI_MCAUSE_HI:EI_MCAUSE_LO]};
          state_d     = ST_REDIRECT;
        end else if (mie_off && bus.mret_instr) begin
          state_d = ST_RETURN;
        end else begin
          csr_wr_en = bus.csr_we;
        end
      end
      ST_REDIRECT: begin
        bus.pc_sel  = PC_SEL_TRAP;
        bus.trap_pc = mtvec[15:0];
        bus.flush   = 1'b1;
        bus.stall   = 1'b1;
      end
      ST_RETURN: begin
        bus.pc_sel  = PC_SEL_RETURN;
        bus.trap_pc = mepc[15:0];
        bus.flush   = 1'b1;
        bus.stall   = 1'b1;
        mstatus_set = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed scenarios plus randomized traffic, all
// compared against a behavioural model of CSR contents and redirect behaviour.
module tb_trap_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ROM_MAX = 32'h0000_007c;

  trap_controller_if bus();

  trap_controller #(
    .MTVEC_RST   (16'h0060),
    .MAX_ROM_SIZE(16'h007c)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: CSR values plus the redirect (if any) the pipeline should see now.
  // redirect: 0 none, 1 jump to trap vector, 2 return to mepc.
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mip;
  int          m_redirect;

  task automatic model_step();
    if (!rst) begin
      m_redirect = 0;
      m_mstatus  = 1;
      m_mtvec    = 32'h60;
      m_mepc     = 0;
      m_mcause   = 0;
      m_mip      = 0;
      return;
    end
    if (m_redirect != 0) begin
      if (m_redirect == 2) m_mstatus = 1;
      m_redirect = 0;
    end else if (m_mstatus == 1 && bus.exception) begin
      m_mepc     = bus.excep_info & 32'hFFFF;
      m_mcause   = (bus.excep_info[31] ? 32'h8000_0000 : 32'h0) | ((bus.excep_info >> 24) & 32'h7F);
      m_mstatus  = 0;
      m_redirect = 1;
    end else if (m_mstatus == 1 && bus.interrup) begin
      m_mepc     = 32'(bus.pc_curr);
      m_mcause   = 32'h8000_0000 | ((bus.excep_info >> 24) & 32'h7F);
      m_mstatus  = 0;
      m_redirect = 1;
    end else if (m_mstatus == 0 && bus.mret_instr) begin
      m_redirect = 2;
    end else if (bus.csr_we) begin
      case (bus.csr_addr)
        12'h300: m_mstatus = bus.csr_wdata;
        12'h305: if (bus.csr_wdata <= ROM_MAX) m_mtvec = bus.csr_wdata & ~32'h3;
        12'h341: if (bus.csr_wdata <= ROM_MAX) m_mepc = bus.csr_wdata & ~32'h3;
        12'h342: m_mcause = bus.csr_wdata;
        12'h344: m_mip = bus.csr_wdata;
        default: ;
      endcase
    end
    m_mip = bus.irq_ext ? (m_mip | 32'h800) : (m_mip & ~32'h800);
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] addr);
    case (addr)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] m_trap_pc();
    if (m_redirect == 1) return m_mtvec[15:0];
    if (m_redirect == 2) return m_mepc[15:0];
    return 16'h0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [31:0] data);
    bus.csr_addr = addr;
    #1;
    data = bus.csr_rdata;
  endtask

  task automatic clear_inputs();
    bus.exception  = 0;
    bus.interrup   = 0;
    bus.excep_info = 0;
    bus.pc_curr    = 0;
    bus.mret_instr = 0;
    bus.irq_ext    = 0;
    bus.csr_we     = 0;
    bus.csr_addr   = 0;
    bus.csr_wdata  = 0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    clear_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
    checks++; if (bus.pc_sel !== 2'b00) begin errors++; $display("FAIL rst_pc_sel got %0h want 0", bus.pc_sel); end
    checks++; if ({bus.flush, bus.stall} !== 2'b00) begin errors++; $display("FAIL rst_flush_stall got %b want 00", {bus.flush, bus.stall}); end
    checks++; if (bus.trap_pc !== 16'h0) begin errors++; $display("FAIL rst_trap_pc got %h want 0000", bus.trap_pc); end
    read_csr(12'h300, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL rst_mstatus got %h want 00000001", d); end
    read_csr(12'h305, d);
    checks++; if (d !== 32'h60) begin errors++; $display("FAIL rst_mtvec got %h want 00000060", d); end
    read_csr(12'h341, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h want 0", d); end
    read_csr(12'h123, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h want 0", d); end
  endtask

  task automatic test_exception_return();
    logic [31:0] d;
    bus.exception  = 1;
    bus.excep_info = 32'h0210_0014;
    tick();
    bus.exception = 0;
    checks++; if (bus.pc_sel !== 2'b01) begin errors++; $display("FAIL exc_pc_sel got %0h want 1", bus.pc_sel); end
    checks++; if (bus.trap_pc !== 16'h0060) begin errors++; $display("FAIL exc_trap_pc got %h want 0060", bus.trap_pc); end
    checks++; if ({bus.flush, bus.stall} !== 2'b11) begin errors++; $display("FAIL exc_flush_stall got %b want 11", {bus.flush, bus.stall}); end
    read_csr(12'h341, d);
    checks++; if (d !== 32'h14) begin errors++; $display("FAIL exc_mepc got %h want 00000014", d); end
    read_csr(12'h342, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL exc_mcause got %h want 00000002", d); end
    checks++; if (bus.mstatus !== 32'h0) begin errors++; $display("FAIL exc_mstatus got %h want 0", bus.mstatus); end
    tick();
    checks++; if (bus.pc_sel !== 2'b00) begin errors++; $display("FAIL redirect_len pc_sel got %0h want 0", bus.pc_sel); end
    bus.mret_instr = 1;
    tick();
    bus.mret_instr = 0;
    checks++; if (bus.pc_sel !== 2'b10) begin errors++; $display("FAIL ret_pc_sel got %0h want 2", bus.pc_sel); end
    checks++; if (bus.trap_pc !== 16'h0014) begin errors++; $display("FAIL ret_trap_pc got %h want 0014", bus.trap_pc); end
    checks++; if (bus.mstatus !== 32'h0) begin errors++; $display("FAIL ret_mstatus_during got %h want 0", bus.mstatus); end
    tick();
    checks++; if (bus.mstatus !== 32'h1) begin errors++; $display("FAIL ret_mstatus_after got %h want 1", bus.mstatus); end
    checks++; if (bus.pc_sel !== 2'b00) begin errors++; $display("FAIL ret_len pc_sel got %0h want 0", bus.pc_sel); end
    // mret while traps are enabled must be ignored
    bus.mret_instr = 1;
    tick();
    bus.mret_instr = 0;
    checks++; if (bus.pc_sel !== 2'b00) begin errors++; $display("FAIL mret_ignored pc_sel got %0h want 0", bus.pc_sel); end
    bus.exception  = 1;
    bus.excep_info = 32'h8300_0024;
    tick();
    bus.exception = 0;
    checks++; if (bus.pc_sel !== 2'b01) begin errors++; $display("FAIL reexc_pc_sel got %0h want 1", bus.pc_sel); end
    read_csr(12'h342, d);
    checks++; if (d !== 32'h8000_0003) begin errors++; $display("FAIL reexc_mcause got %h want 80000003", d); end
    tick();
    bus.mret_instr = 1;
    tick();
    bus.mret_instr = 0;
    tick();
  endtask

  task automatic test_interrupt();
    logic [31:0] d;
    bus.interrup   = 1;
    bus.excep_info = {1'b0, 7'd11, 24'h0};
    bus.pc_curr    = 16'h0020;
    tick();
    bus.interrup = 0;
    checks++; if (bus.pc_sel !== 2'b01) begin errors++; $display("FAIL irq_pc_sel got %0h want 1", bus.pc_sel); end
    read_csr(12'h342, d);
    checks++; if (d !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got %h want 8000000b", d); end
    read_csr(12'h341, d);
    checks++; if (d !== 32'h20) begin errors++; $display("FAIL irq_mepc got %h want 00000020", d); end
    tick();
    bus.mret_instr = 1;
    tick();
    bus.mret_instr = 0;
    tick();
    // exception wins over a simultaneous interrupt
    bus.exception  = 1;
    bus.interrup   = 1;
    bus.excep_info = 32'h0500_0030;
    bus.pc_curr    = 16'h0044;
    tick();
    bus.exception = 0;
    bus.interrup  = 0;
    read_csr(12'h341, d);
    checks++; if (d !== 32'h30) begin errors++; $display("FAIL prio_mepc got %h want 00000030", d); end
    read_csr(12'h342, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL prio_mcause got %h want 00000005", d); end
    tick();
    bus.mret_instr = 1;
    tick();
    bus.mret_instr = 0;
    tick();
  endtask

  task automatic test_csr_write();
    logic [31:0] d;
    bus.csr_we     = 1;
    bus.csr_addr   = 12'h305;
    bus.csr_wdata  = 32'h43;
    bus.exception  = 1;
    bus.excep_info = 32'h0100_0008;
    tick();
    bus.exception = 0;
    checks++; if (bus.trap_pc !== 16'h0060) begin errors++; $display("FAIL wr_with_trap trap_pc got %h want 0060", bus.trap_pc); end
    tick();
    bus.csr_we = 0;
    read_csr(12'h305, d);
    checks++; if (d !== 32'h60) begin errors++; $display("FAIL wr_in_redirect mtvec got %h want 00000060", d); end
    bus.mret_instr = 1;
    tick();
    bus.mret_instr = 0;
    tick();
    bus.csr_we    = 1;
    bus.csr_addr  = 12'h305;
    bus.csr_wdata = 32'h43;
    tick();
    checks++; if (bus.csr_rdata !== 32'h40) begin errors++; $display("FAIL wr_mtvec_align got %h want 00000040", bus.csr_rdata); end
    bus.csr_wdata = 32'h100;
    tick();
    checks++; if (bus.csr_rdata !== 32'h40) begin errors++; $display("FAIL wr_mtvec_range got %h want 00000040", bus.csr_rdata); end
    bus.csr_wdata = 32'h7c;
    tick();
    checks++; if (bus.csr_rdata !== 32'h7c) begin errors++; $display("FAIL wr_mtvec_max got %h want 0000007c", bus.csr_rdata); end
    bus.csr_addr  = 12'h341;
    bus.csr_wdata = 32'h37;
    tick();
    checks++; if (bus.csr_rdata !== 32'h34) begin errors++; $display("FAIL wr_mepc_align got %h want 00000034", bus.csr_rdata); end
    bus.csr_wdata = 32'h81;
    tick();
    checks++; if (bus.csr_rdata !== 32'h34) begin errors++; $display("FAIL wr_mepc_range got %h want 00000034", bus.csr_rdata); end
    bus.csr_addr  = 12'h344;
    bus.csr_wdata = 32'hFFFF_FFFF;
    bus.irq_ext   = 0;
    tick();
    checks++; if (bus.mip !== 32'hFFFF_F7FF) begin errors++; $display("FAIL wr_mip got %h want fffff7ff", bus.mip); end
    bus.csr_we  = 0;
    bus.irq_ext = 1;
    tick();
    checks++; if (bus.mip !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mip_irq got %h want ffffffff", bus.mip); end
    bus.csr_we    = 1;
    bus.csr_addr  = 12'h305;
    bus.csr_wdata = 32'h60;
    bus.irq_ext   = 0;
    tick();
    bus.csr_we = 0;
  endtask

  task automatic test_masked_and_reset();
    logic [31:0] d;
    bus.csr_we    = 1;
    bus.csr_addr  = 12'h300;
    bus.csr_wdata = 32'h0;
    tick();
    bus.csr_we     = 0;
    bus.exception  = 1;
    bus.excep_info = 32'h0700_0010;
    tick();
    bus.exception = 0;
    checks++; if (bus.pc_sel !== 2'b00) begin errors++; $display("FAIL masked_pc_sel got %0h want 0", bus.pc_sel); end
    read_csr(12'h341, d);
    checks++; if (d !== 32'h34) begin errors++; $display("FAIL masked_mepc got %h want 00000034", d); end
    bus.csr_we    = 1;
    bus.csr_addr  = 12'h300;
    bus.csr_wdata = 32'h1;
    tick();
    bus.csr_we     = 0;
    bus.exception  = 1;
    tick();
    bus.exception = 0;
    checks++; if (bus.pc_sel !== 2'b01) begin errors++; $display("FAIL pre_abort pc_sel got %0h want 1", bus.pc_sel); end
    rst = 0;
    tick();
    rst = 1;
    checks++; if (bus.pc_sel !== 2'b00 || bus.flush !== 1'b0) begin errors++; $display("FAIL abort_pc_sel got %0h/%b want 0/0", bus.pc_sel, bus.flush); end
    checks++; if (bus.mstatus !== 32'h1) begin errors++; $display("FAIL abort_mstatus got %h want 1", bus.mstatus); end
    read_csr(12'h341, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL abort_mepc got %h want 0", d); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h344, 12'h1A5};
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 59) != 0);
      bus.exception  = ($urandom_range(0, 4) == 0);
      bus.interrup   = ($urandom_range(0, 3) == 0);
      bus.mret_instr = ($urandom_range(0, 2) == 0);
      bus.irq_ext    = 1'($urandom);
      bus.excep_info = $urandom;
      bus.pc_curr    = 16'($urandom);
      bus.csr_we     = 1'($urandom);
      bus.csr_addr   = addrs[$urandom_range(0, 5)];
      if (bus.csr_addr == 12'h300) bus.csr_wdata = $urandom_range(0, 2);
      else if ($urandom_range(0, 3) == 0) bus.csr_wdata = $urandom;
      else bus.csr_wdata = $urandom_range(0, 160);
      tick();
      checks++; if (bus.pc_sel !== 2'(m_redirect)) begin errors++; $display("FAIL rnd_pc_sel cyc %0d got %0h want %0h", i, bus.pc_sel, m_redirect); end
      checks++; if (bus.trap_pc !== m_trap_pc()) begin errors++; $display("FAIL rnd_trap_pc cyc %0d got %h want %h", i, bus.trap_pc, m_trap_pc()); end
      checks++; if ({bus.flush, bus.stall} !== {2{m_redirect != 0}}) begin errors++; $display("FAIL rnd_flush_stall cyc %0d got %b", i, {bus.flush, bus.stall}); end
      checks++; if (bus.mstatus !== m_mstatus || bus.mip !== m_mip) begin errors++; $display("FAIL rnd_status cyc %0d got %h/%h want %h/%h", i, bus.mstatus, bus.mip, m_mstatus, m_mip); end
      checks++; if (bus.csr_rdata !== m_read(bus.csr_addr)) begin errors++; $display("FAIL rnd_rdata cyc %0d addr %h got %h want %h", i, bus.csr_addr, bus.csr_rdata, m_read(bus.csr_addr)); end
    end
    rst = 1;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_exception_return();
    test_interrupt();
    test_csr_write();
    test_masked_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameter MTVEC_RST, default 16'h0060, reset trap-vector address.
REQ-002 Parameter MAX_ROM_SIZE, default 16'h007c, highest legal PC; also the upper bound for legal mtvec/mepc writes.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 exception  in  1  exception flag from the exception verifier.
REQ-006 interrup  in  1  interrupt flag from the exception verifier.
REQ-007 excep_info  in  32  {cause_type[31], mcause[30:24], mstatus_hint[23:16], mret[15:0]}.
REQ-008 pc_curr  in  16  PC of the instruction in decode.
REQ-009 mret_instr  in  1  decoder flags an mret instruction.
REQ-010 irq_ext  in  1  external interrupt line.
REQ-011 csr_we  in  1, csr_addr  in  12, csr_wdata  in  32: CSR write port.
REQ-012 csr_rdata  out  32  combinational read of csr_addr; unmapped addresses read 0.
REQ-013 mstatus, mip  out  32 each  current CSR values, fed back to the exception verifier.
REQ-014 pc_sel  out  2  00 normal, 01 trap vector, 10 return; trap_pc  out  16  redirect target.
REQ-015 flush  out  1, stall  out  1  pipeline control.

Function
REQ-016 CSR map: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mip 0x344.
REQ-017 FSM states: IDLE, REDIRECT, RETURN; each of REDIRECT and RETURN lasts exactly 1 cycle and then goes to IDLE.
REQ-018 IDLE with mstatus==1 and exception==1 on an edge: mepc<={16'h0,excep_info[15:0]}, mcause<={excep_info[31],24'h0,excep_info[30:24]}, mstatus<=0, go to REDIRECT.
REQ-019 IDLE with mstatus==1, interrup==1, exception==0: mepc<={16'h0,pc_curr}, mcause<={1'b1,24'h0,excep_info[30:24]}, mstatus<=0, go to REDIRECT.
REQ-020 REDIRECT: pc_sel=01, trap_pc=mtvec[15:0], flush=1, stall=1.
REQ-021 IDLE with mstatus==0 and mret_instr==1: go to RETURN.
REQ-022 RETURN: pc_sel=10, trap_pc=mepc[15:0], flush=1, stall=1; mstatus<=1 on the exit edge.
REQ-023 mret_instr with mstatus==1 is ignored.
REQ-024 Priority within IDLE: exception > interrupt > mret > CSR write; a CSR write in the same cycle as a taken trap or return is dropped.
REQ-025 CSR writes are accepted only in IDLE; a write arriving in REDIRECT or RETURN is dropped.
REQ-026 mtvec and mepc writes force bits [1:0]=0.
REQ-027 mtvec and mepc writes with a value above MAX_ROM_SIZE are dropped.
REQ-028 mip[11] is recomputed every cycle as irq_ext; the other mip bits are software-written.
REQ-029 In IDLE, outside any trap or return, pc_sel=00, flush=0, stall=0, trap_pc=0.

Reset
REQ-030 When rst==0 at an edge: state=IDLE, mstatus=1, mtvec={16'h0,MTVEC_RST}, mepc=0, mcause=0, mip=0.
REQ-031 Outputs after reset: pc_sel=00, flush=0, stall=0, trap_pc=0.
REQ-032 Reset asserted in REDIRECT or RETURN aborts the redirect; the next cycle is IDLE with reset values.

Structure
REQ-033 Shared package trap_pkg holds: CSR address constants, FSM state encoding, pc_sel encodings, excep_info field bounds, reset constants.
REQ-034 One sub-module, trap_csr_file, holds CSR storage, the write masking of REQ-026/027 and the read mux.
REQ-035 The FSM and trap priority logic reside in trap_controller.

Verification
REQ-036 Reset, then read 0x300 and 0x305 -> 32'h1 and 32'h0060; pc_sel=00.
REQ-037 exception=1, excep_info=32'h02100014 -> next cycle pc_sel=01, trap_pc=16'h0060, flush=1; mepc=32'h14, mcause=32'h2, mstatus=0.
REQ-038 After REQ-037, mret_instr=1 -> RETURN with trap_pc=16'h0014; mstatus=1 afterwards; a further exception is accepted again.
REQ-039 interrup=1, excep_info[30:24]=7'd11, pc_curr=16'h0020 -> mcause=32'h8000000B, mepc=32'h20.
REQ-040 csr_we to 0x305 with 32'h0000_0043 in the same cycle as exception=1 -> mtvec stays 0x60; alone -> mtvec=32'h40; with 32'h0000_0100 -> dropped.
REQ-041 exception=1 while mstatus==0 -> no state change; reset pulsed during REDIRECT -> IDLE, pc_sel=00 next cycle.
